// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port of mem_port_arbiter.
// Ports: requester side (inputReq*/inputAddr*/inputWdata*/inputWnR*, outputAck*/outputRdata/outputError)
//        memory side (memSelect/memWnR/memAddress/memWdata out, memRdata/memValid in).
interface mem_port_arbiter_if;
    // requester port 0 (instruction fetch)
    logic        inputReq0;
    logic [15:0] inputAddr0;
    logic [15:0] inputWdata0;
    logic        inputWnR0;
    // requester port 1 (data)
    logic        inputReq1;
    logic [15:0] inputAddr1;
    logic [15:0] inputWdata1;
    logic        inputWnR1;
    // completion back to requesters
    logic        outputAck0;
    logic        outputAck1;
    logic [15:0] outputRdata;
    logic        outputError;
    // shared memory port
    logic        memSelect;
    logic        memWnR;
    logic [15:0] memAddress;
    logic [15:0] memWdata;
    logic [15:0] memRdata;
    logic        memValid;

    // arbiter side
    modport slave (
        input  inputReq0, inputAddr0, inputWdata0, inputWnR0,
        input  inputReq1, inputAddr1, inputWdata1, inputWnR1,
        input  memRdata, memValid,
        output outputAck0, outputAck1, outputRdata, outputError,
        output memSelect, memWnR, memAddress, memWdata
    );

    // requester/memory side
    modport master (
        output inputReq0, inputAddr0, inputWdata0, inputWnR0,
        output inputReq1, inputAddr1, inputWdata1, inputWnR1,
        output memRdata, memValid,
        input  outputAck0, outputAck1, outputRdata, outputError,
        input  memSelect, memWnR, memAddress, memWdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of two requesters onto one 16-bit memory port, one access at a time, with timeout.
// Latency: grant 1 cycle after req; ack 1 cycle after memValid (or after TIMEOUT_CYCLES busy cycles); 1 dead cycle after ack.
// Backpressure: requests are level-held until ack; new requests are only sampled in IDLE, so the loser simply waits.
// Ports: clk, rstn (async active-low), bus (mem_port_arbiter_if.slave: requester ports 0/1 and memory port).
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
) (
    input  logic                clk,
    input  logic                rstn,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t             state_q,      state_d;
    logic               last_grant_q, last_grant_d;  // also selects which ack fires
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic               mem_select_q, mem_select_d;
    logic               mem_wnr_q,    mem_wnr_d;
    logic [15:0]        mem_addr_q,   mem_addr_d;
    logic [15:0]        mem_wdata_q,  mem_wdata_d;
    logic               ack0_q,       ack0_d;
    logic               ack1_q,       ack1_d;
    logic               error_q,      error_d;
    logic [15:0]        rdata_q,      rdata_d;

    logic               any_req;
    logic               winner;

    always_comb begin
        any_req = bus.inputReq0 | bus.inputReq1;
        // On a tie the port that did not win last time goes; otherwise the lone requester.
        winner  = (bus.inputReq0 & bus.inputReq1) ? ~last_grant_q : bus.inputReq1;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_select_d = mem_select_q;
        mem_wnr_d    = mem_wnr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        error_d      = 1'b0;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                // A memValid seen here belongs to no access of ours; hold off one cycle.
                if (any_req && !bus.memValid) begin
                    last_grant_d = winner;
                    mem_addr_d   = winner ? bus.inputAddr1  : bus.inputAddr0;
                    mem_wdata_d  = winner ? bus.inputWdata1 : bus.inputWdata0;
                    mem_wnr_d    = winner ? bus.inputWnR1   : bus.inputWnR0;
                    mem_select_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A response arriving on the timeout cycle still counts as a good completion.
                if (bus.memValid) begin
                    mem_select_d = 1'b0;
                    ack0_d       = ~last_grant_q;
                    ack1_d       = last_grant_q;
                    rdata_d      = mem_wnr_q ? 16'h0000 : bus.memRdata;
                    state_d      = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_select_d = 1'b0;
                    ack0_d       = ~last_grant_q;
                    ack1_d       = last_grant_q;
                    error_d      = 1'b1;
                    rdata_d      = 16'h0000;
                    state_d      = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // Gives the winner the ack edge to drop its request before we sample again.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_select_q <= 1'b0;
            mem_wnr_q    <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 16'h0000;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            error_q      <= 1'b0;
            rdata_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_select_q <= mem_select_d;
            mem_wnr_q    <= mem_wnr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            error_q      <= error_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.memSelect   = mem_select_q;
    assign bus.memWnR      = mem_wnr_q;
    assign bus.memAddress  = mem_addr_q;
    assign bus.memWdata    = mem_wdata_q;
    assign bus.outputAck0  = ack0_q;
    assign bus.outputAck1  = ack1_q;
    assign bus.outputError = error_q;
    assign bus.outputRdata = rdata_q;

endmodule
